// File: rtl/zorro_ac_pkg.sv
// Shared types and constants for the Zorro II AutoConfig responder.
package zorro_ac_pkg;

  typedef enum logic [1:0] {
    S_RAM  = 2'd0,
    S_IDE  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] CFG_PAGE    = 8'hE8;
  localparam logic [7:0] ER_TYPE_IDE = 8'hD1;
  localparam logic [7:0] ER_TYPE_RAM = 8'hE0;

  localparam logic [6:0] OFF_ER_HI   = 7'h00;
  localparam logic [6:0] OFF_ER_LO   = 7'h02;
  localparam logic [6:0] OFF_RSV_HI  = 7'h40;
  localparam logic [6:0] OFF_RSV_LO  = 7'h42;
  localparam logic [6:0] OFF_BASE_HI = 7'h48;
  localparam logic [6:0] OFF_BASE_LO = 7'h4A;
  localparam logic [6:0] OFF_SHUTUP  = 7'h4C;

  function automatic state_e next_board(input state_e s);
    case (s)
      S_RAM:   return S_IDE;
      default: return S_DONE;
    endcase
  endfunction

  // Nibble i of v, counting from the most significant nibble.
  function automatic logic [3:0] nib16(input logic [15:0] v, input logic [1:0] i);
    logic [15:0] s;
    s = v << {i, 2'b00};
    return s[15:12];
  endfunction

  function automatic logic [3:0] nib32(input logic [31:0] v, input logic [2:0] i);
    logic [31:0] s;
    s = v << {i, 2'b00};
    return s[31:28];
  endfunction

endpackage

// File: rtl/zorro_ac_nibble_rom.sv
// Combinational config-space contents for one board, including the
// inversion rule (only er_type and the $40/$42 pair read back true).
module zorro_ac_nibble_rom
  import zorro_ac_pkg::*;
#(
  parameter logic [15:0] MANUF_ID    = 16'h082C,
  parameter logic [7:0]  IDE_PRODUCT = 8'h06,
  parameter logic [7:0]  RAM_PRODUCT = 8'h07,
  parameter logic [31:0] SERIAL      = 32'h0000_0001,
  parameter logic [15:0] IDE_ROM_VEC = 16'h0000
) (
  input  logic       is_ram,
  input  logic [6:0] offset,
  output logic [3:0] nibble
);

  logic [7:0]  er_type;
  logic [7:0]  product;
  logic [15:0] rom_vec;
  logic [2:0]  ser_idx;
  logic [3:0]  raw;
  logic        invert;

  assign er_type = is_ram ? ER_TYPE_RAM : ER_TYPE_IDE;
  assign product = is_ram ? RAM_PRODUCT : IDE_PRODUCT;
  assign rom_vec = is_ram ? 16'h0000 : IDE_ROM_VEC;
  assign ser_idx = 3'(offset[6:1] - 6'd12);

  always_comb begin
    raw    = 4'h0;
    invert = 1'b1;
    case (offset)
      OFF_ER_HI: begin raw = er_type[7:4]; invert = 1'b0; end
      OFF_ER_LO: begin raw = er_type[3:0]; invert = 1'b0; end
      OFF_RSV_HI, OFF_RSV_LO: invert = 1'b0;
      7'h04: raw = product[7:4];
      7'h06: raw = product[3:0];
      7'h10, 7'h12, 7'h14, 7'h16: raw = nib16(MANUF_ID, offset[2:1]);
      7'h18, 7'h1A, 7'h1C, 7'h1E,
      7'h20, 7'h22, 7'h24, 7'h26: raw = nib32(SERIAL, ser_idx);
      7'h28, 7'h2A, 7'h2C, 7'h2E: raw = nib16(rom_vec, offset[2:1]);
      default: raw = 4'h0;
    endcase
    nibble = invert ? ~raw : raw;
  end

endmodule

// File: rtl/zorro_autoconfig.sv
// Zorro II AutoConfig responder: IDE board, plus a Fast RAM board presented
// first when FASTRAM_EN is defined.
module zorro_autoconfig
  import zorro_ac_pkg::*;
#(
  parameter logic [15:0] MANUF_ID    = 16'h082C,
  parameter logic [7:0]  IDE_PRODUCT = 8'h06,
  parameter logic [7:0]  RAM_PRODUCT = 8'h07,
  parameter logic [31:0] SERIAL      = 32'h0000_0001,
  parameter logic [15:0] IDE_ROM_VEC = 16'h0000
) (
  input  logic       CLKCPU,
  input  logic       RESET_n,
  input  logic [7:0] A_HIGH,
  input  logic [5:0] A_LOW,
  input  logic       RW_n,
  input  logic       AS_CPU_n,
  input  logic [3:0] D_IN,
  input  logic       CFGIN_n,
  output logic [3:0] D_OUT,
  output logic       D_OE_n,
  output logic       CFG_DTACK_n,
  output logic       CFGOUT_n,
  output logic [7:0] BASE_IDE,
  output logic       IDE_CONFIGURED_n,
  output logic [7:0] BASE_RAM,
  output logic       RAM_CONFIGURED_n
);

`ifdef FASTRAM_EN
  localparam state_e RESET_STATE = S_RAM;
`else
  localparam state_e RESET_STATE = S_IDE;
`endif

  state_e     state_q, state_d;
  logic [3:0] d_out_q, d_out_d;
  logic       d_oe_n_q, d_oe_n_d;
  logic       dtack_n_q, dtack_n_d;
  logic       cfgout_n_q, cfgout_n_d;
  logic [7:0] base_ide_q, base_ide_d;
  logic       ide_cfg_n_q, ide_cfg_n_d;
  logic [3:0] base_lo_q, base_lo_d;
  logic       wr_seen_q, wr_seen_d;
  logic       cyc_q, cyc_d;
`ifdef FASTRAM_EN
  logic [7:0] base_ram_q, base_ram_d;
  logic       ram_cfg_n_q, ram_cfg_n_d;
`endif

  logic [6:0] offset;
  logic [3:0] rom_nibble;
  logic       cfg_hit;
  logic       wr_fire;

  assign offset  = {A_LOW, 1'b0};
  assign cfg_hit = !CFGIN_n && (state_q != S_DONE) && (A_HIGH == CFG_PAGE) && !AS_CPU_n;
  assign wr_fire = cfg_hit && !RW_n && !wr_seen_q;

  zorro_ac_nibble_rom #(
    .MANUF_ID   (MANUF_ID),
    .IDE_PRODUCT(IDE_PRODUCT),
    .RAM_PRODUCT(RAM_PRODUCT),
    .SERIAL     (SERIAL),
    .IDE_ROM_VEC(IDE_ROM_VEC)
  ) u_rom (
    .is_ram(state_q == S_RAM),
    .offset(offset),
    .nibble(rom_nibble)
  );

  always_comb begin
    state_d     = state_q;
    base_ide_d  = base_ide_q;
    ide_cfg_n_d = ide_cfg_n_q;
    base_lo_d   = base_lo_q;
`ifdef FASTRAM_EN
    base_ram_d  = base_ram_q;
    ram_cfg_n_d = ram_cfg_n_q;
`endif
    d_oe_n_d  = !(cfg_hit && RW_n);
    d_out_d   = (cfg_hit && RW_n) ? rom_nibble : d_out_q;
    // cyc stays set after a state-advancing write so DTACK still completes the cycle.
    cyc_d     = !AS_CPU_n && (cyc_q || cfg_hit);
    dtack_n_d = !(cyc_q && !AS_CPU_n);
    wr_seen_d = !AS_CPU_n && (wr_seen_q || wr_fire);

    if (wr_fire) begin
      case (offset)
        OFF_BASE_LO: base_lo_d = D_IN;
        OFF_BASE_HI: begin
`ifdef FASTRAM_EN
          if (state_q == S_RAM) begin
            base_ram_d  = {D_IN, base_lo_q};
            ram_cfg_n_d = 1'b0;
          end else
`endif
          begin
            base_ide_d  = {D_IN, base_lo_q};
            ide_cfg_n_d = 1'b0;
          end
          state_d = next_board(state_q);
        end
        OFF_SHUTUP: state_d = next_board(state_q);
        default: ;
      endcase
    end

    cfgout_n_d = (state_d == S_DONE) ? 1'b0 : cfgout_n_q;
  end

  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= RESET_STATE;
      d_out_q     <= 4'h0;
      d_oe_n_q    <= 1'b1;
      dtack_n_q   <= 1'b1;
      cfgout_n_q  <= 1'b1;
      base_ide_q  <= 8'h00;
      ide_cfg_n_q <= 1'b1;
      base_lo_q   <= 4'h0;
      wr_seen_q   <= 1'b0;
      cyc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_out_q     <= d_out_d;
      d_oe_n_q    <= d_oe_n_d;
      dtack_n_q   <= dtack_n_d;
      cfgout_n_q  <= cfgout_n_d;
      base_ide_q  <= base_ide_d;
      ide_cfg_n_q <= ide_cfg_n_d;
      base_lo_q   <= base_lo_d;
      wr_seen_q   <= wr_seen_d;
      cyc_q       <= cyc_d;
    end
  end

`ifdef FASTRAM_EN
  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      base_ram_q  <= 8'h00;
      ram_cfg_n_q <= 1'b1;
    end else begin
      base_ram_q  <= base_ram_d;
      ram_cfg_n_q <= ram_cfg_n_d;
    end
  end

  assign BASE_RAM         = base_ram_q;
  assign RAM_CONFIGURED_n = ram_cfg_n_q;
`else
  assign BASE_RAM         = 8'h00;
  assign RAM_CONFIGURED_n = 1'b1;
`endif

  assign D_OUT            = d_out_q;
  assign D_OE_n           = d_oe_n_q;
  assign CFG_DTACK_n      = dtack_n_q;
  assign CFGOUT_n         = cfgout_n_q;
  assign BASE_IDE         = base_ide_q;
  assign IDE_CONFIGURED_n = ide_cfg_n_q;

endmodule

// File: tb/tb_zorro_autoconfig.sv
// Directed bench for zorro_autoconfig; also covers the RAM board when FASTRAM_EN is defined.
module tb_zorro_autoconfig;

  logic       CLKCPU = 1'b0;
  logic       RESET_n;
  logic [7:0] A_HIGH;
  logic [5:0] A_LOW;
  logic       RW_n;
  logic       AS_CPU_n;
  logic [3:0] D_IN;
  logic       CFGIN_n;
  logic [3:0] D_OUT;
  logic       D_OE_n;
  logic       CFG_DTACK_n;
  logic       CFGOUT_n;
  logic [7:0] BASE_IDE;
  logic       IDE_CONFIGURED_n;
  logic [7:0] BASE_RAM;
  logic       RAM_CONFIGURED_n;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] IX_BASE_HI = 6'h24;
  localparam logic [5:0] IX_BASE_LO = 6'h25;
  localparam logic [5:0] IX_SHUTUP  = 6'h26;

  zorro_autoconfig dut (
    .CLKCPU          (CLKCPU),
    .RESET_n         (RESET_n),
    .A_HIGH          (A_HIGH),
    .A_LOW           (A_LOW),
    .RW_n            (RW_n),
    .AS_CPU_n        (AS_CPU_n),
    .D_IN            (D_IN),
    .CFGIN_n         (CFGIN_n),
    .D_OUT           (D_OUT),
    .D_OE_n          (D_OE_n),
    .CFG_DTACK_n     (CFG_DTACK_n),
    .CFGOUT_n        (CFGOUT_n),
    .BASE_IDE        (BASE_IDE),
    .IDE_CONFIGURED_n(IDE_CONFIGURED_n),
    .BASE_RAM        (BASE_RAM),
    .RAM_CONFIGURED_n(RAM_CONFIGURED_n)
  );

  always #5 CLKCPU = ~CLKCPU;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_dout"},  8'(D_OUT), 8'h0);
    chk({tag, "_doe"},   8'(D_OE_n), 8'h1);
    chk({tag, "_dtack"}, 8'(CFG_DTACK_n), 8'h1);
    chk({tag, "_cfgout"}, 8'(CFGOUT_n), 8'h1);
    chk({tag, "_bide"},  BASE_IDE, 8'h00);
    chk({tag, "_idecfg"}, 8'(IDE_CONFIGURED_n), 8'h1);
    chk({tag, "_bram"},  BASE_RAM, 8'h00);
    chk({tag, "_ramcfg"}, 8'(RAM_CONFIGURED_n), 8'h1);
  endtask

  // One read cycle held for two clocks; active=0 means no response expected.
  task automatic rd(input string tag, input logic [5:0] ix, input logic [3:0] exp, input bit active);
    @(negedge CLKCPU);
    A_HIGH = 8'hE8; A_LOW = ix; RW_n = 1'b1; AS_CPU_n = 1'b0;
    @(negedge CLKCPU);
    chk({tag, "_dtk_clk1"}, 8'(CFG_DTACK_n), 8'h1);
    chk({tag, "_oe"}, 8'(D_OE_n), 8'(!active));
    if (active) chk({tag, "_data"}, 8'(D_OUT), 8'(exp));
    @(negedge CLKCPU);
    chk({tag, "_dtk_clk2"}, 8'(CFG_DTACK_n), 8'(!active));
    AS_CPU_n = 1'b1;
    @(negedge CLKCPU);
    chk({tag, "_dtk_end"}, 8'(CFG_DTACK_n), 8'h1);
    chk({tag, "_oe_end"}, 8'(D_OE_n), 8'h1);
  endtask

  // Write cycle held for 'hold' clocks; D_IN switches to d2 after the first clock.
  task automatic wr(input string tag, input logic [5:0] ix, input logic [3:0] d,
                    input logic [3:0] d2, input bit active, input int hold);
    @(negedge CLKCPU);
    A_HIGH = 8'hE8; A_LOW = ix; RW_n = 1'b0; AS_CPU_n = 1'b0; D_IN = d;
    @(negedge CLKCPU);
    D_IN = d2;
    chk({tag, "_dtk_clk1"}, 8'(CFG_DTACK_n), 8'h1);
    repeat (hold - 1) @(negedge CLKCPU);
    chk({tag, "_dtk_held"}, 8'(CFG_DTACK_n), 8'(!active));
    chk({tag, "_oe"}, 8'(D_OE_n), 8'h1);
    AS_CPU_n = 1'b1; RW_n = 1'b1;
    @(negedge CLKCPU);
    chk({tag, "_dtk_end"}, 8'(CFG_DTACK_n), 8'h1);
  endtask

  task automatic ram_first(input string tag);
`ifdef FASTRAM_EN
    rd({tag, "_ram_er_hi"}, 6'h00, 4'hE, 1'b1);
    wr({tag, "_ram_base"}, IX_BASE_HI, 4'h2, 4'h2, 1'b1, 2);
    chk({tag, "_bram"}, BASE_RAM, 8'h20);
    chk({tag, "_ramcfg"}, 8'(RAM_CONFIGURED_n), 8'h0);
    chk({tag, "_cfgout_ram"}, 8'(CFGOUT_n), 8'h1);
`else
    chk({tag, "_bram_off"}, BASE_RAM, 8'h00);
    chk({tag, "_ramcfg_off"}, 8'(RAM_CONFIGURED_n), 8'h1);
`endif
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge CLKCPU);
    #2 RESET_n = 1'b0;
    #1 check_reset(tag);
    AS_CPU_n = 1'b1; RW_n = 1'b1;
    @(negedge CLKCPU);
    RESET_n = 1'b1;
    ram_first(tag);
  endtask

  initial begin
    RESET_n = 1'b0; A_HIGH = 8'h00; A_LOW = 6'h00; RW_n = 1'b1;
    AS_CPU_n = 1'b1; D_IN = 4'h0; CFGIN_n = 1'b0;
    repeat (2) @(negedge CLKCPU);
    check_reset("rst0");
    RESET_n = 1'b1;
    ram_first("boot");

    // IDE board contents
    rd("er_hi",   6'h00, 4'hD, 1'b1);
    rd("er_lo",   6'h01, 4'h1, 1'b1);
    rd("prod_hi", 6'h02, 4'hF, 1'b1);
    rd("prod_lo", 6'h03, 4'h9, 1'b1);
    rd("flags",   6'h04, 4'hF, 1'b1);
    rd("man0",    6'h08, 4'hF, 1'b1);
    rd("man1",    6'h09, 4'h7, 1'b1);
    rd("man2",    6'h0A, 4'hD, 1'b1);
    rd("man3",    6'h0B, 4'h3, 1'b1);
    rd("ser0",    6'h0C, 4'hF, 1'b1);
    rd("ser7",    6'h13, 4'hE, 1'b1);
    rd("romvec",  6'h17, 4'hF, 1'b1);
    rd("unused",  6'h1F, 4'hF, 1'b1);
    rd("rsv40",   6'h20, 4'h0, 1'b1);

    // Chain not enabled: no response, no capture
    CFGIN_n = 1'b1;
    rd("cfgin_rd", 6'h00, 4'h0, 1'b0);
    wr("cfgin_wr", IX_BASE_HI, 4'hE, 4'hE, 1'b0, 2);
    chk("cfgin_bide", BASE_IDE, 8'h00);
    chk("cfgin_idecfg", 8'(IDE_CONFIGURED_n), 8'h1);
    chk("cfgin_cfgout", 8'(CFGOUT_n), 8'h1);
    CFGIN_n = 1'b0;

    // Partial base nibble discarded by reset
    wr("lo7", IX_BASE_LO, 4'h7, 4'h7, 1'b1, 2);
    chk("lo7_idecfg", 8'(IDE_CONFIGURED_n), 8'h1);
    chk("lo7_cfgout", 8'(CFGOUT_n), 8'h1);
    pulse_reset("rst1");
    wr("hiE", IX_BASE_HI, 4'hE, 4'hE, 1'b1, 2);
    chk("hiE_bide", BASE_IDE, 8'hE0);
    chk("hiE_idecfg", 8'(IDE_CONFIGURED_n), 8'h0);
    chk("hiE_cfgout", 8'(CFGOUT_n), 8'h0);
    rd("done_rd", 6'h00, 4'h0, 1'b0);

    // Held write latches once even though D_IN changes mid-cycle
    pulse_reset("rst2");
    wr("lo9_hold", IX_BASE_LO, 4'h9, 4'h5, 1'b1, 5);
    wr("hiE9", IX_BASE_HI, 4'hE, 4'hE, 1'b1, 2);
    chk("e9_bide", BASE_IDE, 8'hE9);
    chk("e9_idecfg", 8'(IDE_CONFIGURED_n), 8'h0);
    chk("e9_cfgout", 8'(CFGOUT_n), 8'h0);

    // Shut-up
    pulse_reset("rst3");
    wr("shutup", IX_SHUTUP, 4'h0, 4'h0, 1'b1, 2);
    chk("shut_idecfg", 8'(IDE_CONFIGURED_n), 8'h1);
    chk("shut_bide", BASE_IDE, 8'h00);
    chk("shut_cfgout", 8'(CFGOUT_n), 8'h0);
    rd("shut_rd", 6'h00, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
